// File: rtl/shift_chk_pkg.sv
// Shared types and helpers for the walking-one pattern checker.
// Functions work on a fixed 32-bit container; callers zero-extend narrower buses.
package shift_chk_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int MAX_W     = 32;

  // Rotate the low w bits of v by one position; bits above w stay zero.
  function automatic logic [MAX_W-1:0] rotate(input logic [MAX_W-1:0] v,
                                               input int w, input int dir);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    mask = ~({MAX_W{1'b1}} << w);
    if (dir == DIR_LEFT) r = (v << 1) | (v >> (w - 1));
    else                 r = (v >> 1) | (v << (w - 1));
    return r & mask;
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic int onehot_index(input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] t;
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      t = v >> i;
      if (t[0]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/shift_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with
// increment lands on 1 so the coincident event is not lost.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count <= '0;
    else if (clr)                     count <= inc ? W'(1) : '0;
    else if (inc && (count != '1))    count <= count + 1'b1;
  end

endmodule

// File: rtl/shift_pattern_checker.sv
// Receive-side monitor for a walking-one shift register: locks onto the rotating
// one-hot sequence, tracks position, counts errors. SHIFT_CHK_STALL_TIMEOUT_EN adds a stall timeout.
module shift_pattern_checker
  import shift_chk_pkg::*;
#(
  parameter int CNT_SIZE    = 4,
  parameter int DIR         = 0,
  parameter int LOCK_CNT    = 3,
  parameter int ERR_CNT_W   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CNT_SIZE-1:0]         cnt_in,
  input  logic                        err_clr,
  output logic                        locked,
  output logic                        err_pulse,
  output logic [ERR_CNT_W-1:0]        err_count,
  output logic [$clog2(CNT_SIZE)-1:0] cur_pos,
  output state_t                      fsm_state
);

  localparam int POS_W  = $clog2(CNT_SIZE);
  localparam int MCNT_W = $clog2(LOCK_CNT + 1);

  state_t              state, state_n;
  logic [CNT_SIZE-1:0] last_val;
  logic [MCNT_W-1:0]   match_cnt, match_n;
  logic [POS_W-1:0]    pos_n, in_pos;
  logic                err_n, step, valid, hit, stall_to;

  assign step   = (cnt_in != last_val);
  assign valid  = is_onehot(MAX_W'(cnt_in));
  assign hit    = (rotate(MAX_W'(last_val), CNT_SIZE, DIR) == MAX_W'(cnt_in));
  assign in_pos = POS_W'(onehot_index(MAX_W'(cnt_in)));
  assign fsm_state = state;

`ifdef SHIFT_CHK_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt;

  sat_counter #(.W(STALL_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state == LOCKED) && !step),
    .clr   ((state != LOCKED) || step),
    .count (stall_cnt)
  );

  assign stall_to = (state == LOCKED) && !step &&
                    (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign stall_to       = 1'b0;
`endif

  always_comb begin
    state_n = state;
    match_n = match_cnt;
    pos_n   = cur_pos;
    err_n   = 1'b0;
    case (state)
      SEARCH: begin
        if (step && valid) begin
          state_n = ACQUIRE;
          match_n = MCNT_W'(1);
          pos_n   = in_pos;
        end
      end
      ACQUIRE: begin
        if (step) begin
          if (hit) begin
            match_n = match_cnt + 1'b1;
            pos_n   = in_pos;
            if (match_n == MCNT_W'(LOCK_CNT)) state_n = LOCKED;
          end else if (valid) begin
            match_n = MCNT_W'(1);
            pos_n   = in_pos;
          end else begin
            state_n = SEARCH;
            match_n = '0;
          end
        end
      end
      LOCKED: begin
        // cur_pos keeps the last good index when the sequence breaks
        if (step && hit) begin
          pos_n = in_pos;
        end else if (step || stall_to) begin
          err_n   = 1'b1;
          state_n = SEARCH;
          match_n = '0;
        end
      end
      default: begin
        state_n = SEARCH;
        match_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      last_val  <= '0;
      match_cnt <= '0;
      cur_pos   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      cur_pos   <= pos_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= err_n;
      if (step) last_val <= cnt_in;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_n),
    .clr   (err_clr),
    .count (err_count)
  );

endmodule

// File: tb/tb_shift_pattern_checker.sv
// Directed bench for shift_pattern_checker: left-rotating DUT plus a right-rotating
// instance; stall-timeout expectations follow SHIFT_CHK_STALL_TIMEOUT_EN.
module tb_shift_pattern_checker;
  import shift_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [3:0] cnt_in = 4'b0000;
  logic [3:0] cnt_r = 4'b0000;

  logic       locked, err_pulse, locked_r, err_pulse_r;
  logic [7:0] err_count, err_count_r;
  logic [1:0] cur_pos, cur_pos_r;
  state_t     fsm_state, state_r;

  int n_cmp = 0;
  int n_fail = 0;
  int pulses = 0;
  int pulses_r = 0;
  int exp_pulses = 0;
  logic [1:0] exp_q[$];

  shift_pattern_checker #(.CNT_SIZE(4), .DIR(0), .LOCK_CNT(3), .ERR_CNT_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .err_clr(err_clr), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .cur_pos(cur_pos), .fsm_state(fsm_state)
  );

  shift_pattern_checker #(.CNT_SIZE(4), .DIR(1), .LOCK_CNT(3), .ERR_CNT_W(8), .TIMEOUT_CYC(16)) dut_r (
    .clk(clk), .rst(rst), .cnt_in(cnt_r), .err_clr(err_clr), .locked(locked_r),
    .err_pulse(err_pulse_r), .err_count(err_count_r), .cur_pos(cur_pos_r), .fsm_state(state_r)
  );

  // clock / pulse monitors
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_pulse === 1'b1)   pulses++;
    if (err_pulse_r === 1'b1) pulses_r++;
  end

  // driver tasks: change at negedge, land just after the sampling posedge
  task automatic apply(input logic [3:0] v);
    @(negedge clk); cnt_in = v;
    @(posedge clk); #1;
  endtask

  task automatic apply_r(input logic [3:0] v);
    @(negedge clk); cnt_r = v;
    @(posedge clk); #1;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    n_cmp++; if (cur_pos !== 2'd0) begin n_fail++; $display("FAIL reset_cur_pos: got %0d want 0", cur_pos); end
    n_cmp++; if (fsm_state !== SEARCH) begin n_fail++; $display("FAIL reset_state: got %0d want SEARCH", fsm_state); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_left();
    logic [3:0] seq [5];
    logic       exp_lock [5];
    logic [1:0] e;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_lock = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      apply(seq[i]);
      e = exp_q.pop_front();
      n_cmp++; if (locked !== exp_lock[i]) begin n_fail++; $display("FAIL lock_step%0d: locked=%b want %b", i, locked, exp_lock[i]); end
      n_cmp++; if (cur_pos !== e) begin n_fail++; $display("FAIL pos_step%0d: cur_pos=%0d want %0d", i, cur_pos, e); end
      hold(3);
      n_cmp++; if (locked !== exp_lock[i]) begin n_fail++; $display("FAIL lock_hold%0d: locked=%b want %b", i, locked, exp_lock[i]); end
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL lock_no_err: pulses=%0d want 0", pulses); end
  endtask

  task automatic test_error();
    apply(4'b0010);
    apply(4'b1000);
    exp_pulses++;
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL err_pulse_hi: got %b want 1", err_pulse); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL err_count_1: got %0d want 1", err_count); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL err_unlock: got %b want 0", locked); end
    n_cmp++; if (cur_pos !== 2'd1) begin n_fail++; $display("FAIL err_pos_hold: got %0d want 1", cur_pos); end
    n_cmp++; if (fsm_state !== SEARCH) begin n_fail++; $display("FAIL err_state: got %0d want SEARCH", fsm_state); end
    hold(1);
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL err_pulse_one: got %b want 0", err_pulse); end
    apply(4'b0001);
    apply(4'b0010);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", locked); end
    apply(4'b0100);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %b want 1", locked); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL arst_locked: got %b want 0", locked); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL arst_err_count: got %0d want 0", err_count); end
    n_cmp++; if (cur_pos !== 2'd0) begin n_fail++; $display("FAIL arst_cur_pos: got %0d want 0", cur_pos); end
    n_cmp++; if (fsm_state !== SEARCH) begin n_fail++; $display("FAIL arst_state: got %0d want SEARCH", fsm_state); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // input still 0100: differs from the cleared last value, so it is a step
    @(posedge clk); #1;
    n_cmp++; if (fsm_state !== ACQUIRE) begin n_fail++; $display("FAIL post_rst_step: state=%0d want ACQUIRE", fsm_state); end
    n_cmp++; if (cur_pos !== 2'd2) begin n_fail++; $display("FAIL post_rst_pos: got %0d want 2", cur_pos); end
  endtask

  task automatic test_invalid_acquire();
    apply(4'b1000);
    apply(4'b0000);
    n_cmp++; if (fsm_state !== SEARCH) begin n_fail++; $display("FAIL zero_search: state=%0d want SEARCH", fsm_state); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL zero_no_err: err_count=%0d want 0", err_count); end
    apply(4'b0001);
    apply(4'b0110);
    n_cmp++; if (fsm_state !== SEARCH) begin n_fail++; $display("FAIL multi_search: state=%0d want SEARCH", fsm_state); end
    apply(4'b0001);
    apply(4'b0010);
    apply(4'b1000);
    n_cmp++; if (fsm_state !== ACQUIRE) begin n_fail++; $display("FAIL restart_state: state=%0d want ACQUIRE", fsm_state); end
    n_cmp++; if (cur_pos !== 2'd3) begin n_fail++; $display("FAIL restart_pos: got %0d want 3", cur_pos); end
    apply(4'b0001);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL restart_count: locked=%b want 0", locked); end
    apply(4'b0010);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL restart_lock: locked=%b want 1", locked); end
    n_cmp++; if (pulses !== exp_pulses) begin n_fail++; $display("FAIL acq_no_err: pulses=%0d want %0d", pulses, exp_pulses); end
  endtask

  task automatic test_saturation();
    apply(4'b0100);
    for (int i = 0; i < 260; i++) begin
      apply(4'b0000);
      exp_pulses++;
      if (i == 99) begin
        n_cmp++; if (err_count !== 8'd100) begin n_fail++; $display("FAIL err_count_100: got %0d want 100", err_count); end
      end
      apply(4'b0001); apply(4'b0010); apply(4'b0100);
    end
    n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    @(negedge clk); cnt_in = 4'b0000; err_clr = 1'b1;
    @(posedge clk); #1;
    exp_pulses++;
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL clr_with_err: got %0d want 1", err_count); end
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clr_alone: got %0d want 0", err_count); end
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic test_stall();
    apply(4'b0001); apply(4'b0010); apply(4'b0100);
    apply(4'b1000); apply(4'b0001); apply(4'b0010);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stall_pre_lock: got %b want 1", locked); end
`ifdef SHIFT_CHK_STALL_TIMEOUT_EN
    hold(15);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stall_early: locked=%b want 1", locked); end
    hold(1);
    exp_pulses++;
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL stall_pulse: got %b want 1", err_pulse); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stall_unlock: got %b want 0", locked); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", err_count); end
`else
    hold(20);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL static_hold: locked=%b want 1", locked); end
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL static_count: got %0d want 0", err_count); end
`endif
  endtask

  task automatic test_dir_right();
    apply_r(4'b0001); apply_r(4'b0010); apply_r(4'b0100); apply_r(4'b1000);
    n_cmp++; if (locked_r !== 1'b0) begin n_fail++; $display("FAIL right_left_nolock: got %b want 0", locked_r); end
    n_cmp++; if (err_count_r !== 8'd0) begin n_fail++; $display("FAIL right_left_noerr: got %0d want 0", err_count_r); end
    apply_r(4'b0000);
    apply_r(4'b1000); apply_r(4'b0100);
    n_cmp++; if (locked_r !== 1'b0) begin n_fail++; $display("FAIL right_early: got %b want 0", locked_r); end
    apply_r(4'b0010);
    n_cmp++; if (locked_r !== 1'b1) begin n_fail++; $display("FAIL right_lock: got %b want 1", locked_r); end
    n_cmp++; if (cur_pos_r !== 2'd1) begin n_fail++; $display("FAIL right_pos: got %0d want 1", cur_pos_r); end
    apply_r(4'b0001);
    n_cmp++; if (cur_pos_r !== 2'd0) begin n_fail++; $display("FAIL right_wrap: got %0d want 0", cur_pos_r); end
    n_cmp++; if (locked_r !== 1'b1) begin n_fail++; $display("FAIL right_wrap_lock: got %b want 1", locked_r); end
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_lock_left();
    test_error();
    test_async_reset();
    test_invalid_acquire();
    test_saturation();
    test_stall();
    test_dir_right();
    hold(2);
    n_cmp++; if (pulses !== exp_pulses) begin n_fail++; $display("FAIL pulse_total: got %0d want %0d", pulses, exp_pulses); end
    n_cmp++; if (pulses_r !== 0) begin n_fail++; $display("FAIL right_pulses: got %0d want 0", pulses_r); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_pattern_checker.md
Name: shift_pattern_checker

Overview:
- Receive-side monitor for the walking-one LED shift register output (cnt bus).
- Watches the parallel pattern, locks onto a valid rotating one-hot sequence, and tracks position.
- Flags and counts sequence errors. Sits beside the LED shift register in the same clock domain and feeds status LEDs and the simulation bench.

Parameters:
- CNT_SIZE, 4, width of the observed pattern bus (≥2).
- DIR, 0, expected rotation: 0 = left (0001→0010→0100→1000→0001), 1 = right.
- LOCK_CNT, 3, consecutive correct one-hot values (including the first) needed to lock (≥2).
- ERR_CNT_W, 8, width of the saturating error counter.
- TIMEOUT_CYC, 1024, stall limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cnt_in  in  CNT_SIZE  pattern from the shift register; same clock domain, no synchroniser.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while the sequence is locked.
- err_pulse  out  1  one-cycle strobe per detected error.
- err_count  out  ERR_CNT_W  saturating count of errors.
- cur_pos  out  $clog2(CNT_SIZE)  bit index of the current one-hot bit.

Behaviour:
- One clock; asynchronous active-high reset.
- Reset values:
  - state = SEARCH
  - last_val = 0, match_cnt = 0
  - locked = 0, err_pulse = 0, err_count = 0, cur_pos = 0
- Step event: cnt_in != last_val at a rising edge. last_val <= cnt_in on every step. A held value is not an event.
- expected = last_val rotated by one bit in direction DIR, wrapping (MSB↔LSB).
- valid = cnt_in is exactly one-hot. 0 and multi-hot are invalid.
- All outputs are registered and update at the same edge that samples the step (latency 1 edge).
- SEARCH:
  - On a step with valid: match_cnt = 1, cur_pos = index, go to ACQUIRE.
  - Otherwise remain in SEARCH.
- ACQUIRE, on a step:
  - cnt_in == expected: match_cnt++, cur_pos updates. When match_cnt reaches LOCK_CNT, go to LOCKED and set locked = 1 at this edge.
  - valid but not expected: restart with match_cnt = 1 and cur_pos = new index.
  - invalid: go to SEARCH.
  - No errors are counted in ACQUIRE.
- LOCKED, on a step:
  - cnt_in == expected: update cur_pos.
  - Otherwise: err_pulse = 1 for one cycle, err_count++, locked = 0, go to SEARCH. cur_pos holds its last good value.
- err_count:
  - Saturates at all-ones; no wrap.
  - err_clr alone → 0.
  - err_clr together with a new error → 1.
- Reset mid-sequence: immediate return to reset values. The first post-reset step restarts acquisition.
- First post-reset value (e.g. 0001) differs from last_val = 0, so it counts as a step.

Optional Feature:
- Macro: SHIFT_CHK_STALL_TIMEOUT_EN.
- Defined:
  - A stall counter increments each cycle in LOCKED with no step and clears on any step.
  - When it reaches TIMEOUT_CYC: err_pulse, err_count++, locked = 0, go to SEARCH.
- Undefined:
  - No stall counter; TIMEOUT_CYC is ignored.
  - LOCKED holds indefinitely on a static input.

Decomposition:
- Package shift_chk_pkg holds:
  - the state enum (SEARCH, ACQUIRE, LOCKED)
  - the DIR_LEFT/DIR_RIGHT constants
  - a rotate function
  - a one-hot check function
  - a one-hot→index function
- One sub-module, sat_counter (parameterised width, inc/clr, saturating), used for err_count and reusable for the stall counter.

Test Plan:
- Reset high 30 ns, then drive 0001,0010,0100,1000,0001, each held 4 cycles → locked rises at the edge sampling 0100; cur_pos = 2,3,0 after; err_pulse never high.
- Locked, then inject 0100 after 0010 → wait, that is correct. Instead inject 1000 after 0010 → err_pulse for exactly one cycle, err_count = 1, locked = 0. Resume 0001,0010,0100 → relock at the third value.
- Input 0000 or 0110 during ACQUIRE → state SEARCH, match_cnt reset, err_count unchanged.
- Force 256+ errors with ERR_CNT_W = 8 → err_count stays 255. Then err_clr plus an error in the same cycle → err_count = 1.
- DIR = 1: sequence 1000,0100,0010 → locked. Left-rotating input → no lock, no errors.
- Build with SHIFT_CHK_STALL_TIMEOUT_EN and TIMEOUT_CYC = 16: lock, then hold 0010 for 16 cycles → err_pulse, locked = 0. Without the macro the same stimulus keeps locked = 1.
- Assert rst mid-LOCKED → all outputs reach reset values asynchronously, before the next clk edge.
